gin_buffered_bus: RTL

- Next-generation global-input-network row bus for the PE array.
- Takes one tagged value stream from the slave side and multicasts each value to every master whose scan-loaded ID matches the tag.
- Each master has its own FIFO, so a stalled PE only back-pressures values addressed to it.
- Adds a broadcast tag, a drop counter for unmatched tags, and a busy status output.

---
 rtl/gin_buffered_bus.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gin_buffered_bus.sv
`default_nettype none
// ============================================================================
//  Module   : gin_buffered_bus
//  Brief    : Global-input-network row bus. Multicasts each tagged value from
//             the slave side into a private FIFO of every master whose
//             scan-loaded ID matches the tag. Supports a broadcast tag, counts
//             unmatched transfers and reports a busy status.
//  Revision : 1.0  initial release
// ============================================================================
module gin_buffered_bus #(
   parameter int MASTER_NUMS = 14,
   parameter int ID_LEN      = 5,
   parameter int VALUE_LEN   = 32,
   parameter int MA_Y        = 0,
   parameter int FIFO_DEPTH  = 2,
   parameter int BCAST_EN    = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  ready,
   input  logic [VALUE_LEN+ID_LEN:0]             enable_tag_value,
   input  logic [MASTER_NUMS-1:0]                master_ready,
   output logic [(VALUE_LEN+1)*MASTER_NUMS-1:0]  master_enable_data,
   input  logic                                  set_id,
   input  logic [ID_LEN-1:0]                     id_scan_in,
   output logic [ID_LEN-1:0]                     id_scan_out,
   output logic [15:0]                           drop_cnt,
   output logic                                  busy
);

   localparam int              PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [15:0]     C_SAT   = 16'hFFFF;

   // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally;
   // MA_Y is a debug-only row index and must be non-negative.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MA_Y < 0) begin : g_bad_params
      $error("gin_buffered_bus: illegal FIFO_DEPTH or MA_Y");
   end

   // Slave-side field split
   logic                  enable_w;
   logic [ID_LEN-1:0]     tag_w;
   logic [VALUE_LEN-1:0]  value_w;

   assign enable_w = enable_tag_value[VALUE_LEN+ID_LEN];
   assign tag_w    = enable_tag_value[VALUE_LEN +: ID_LEN];
   assign value_w  = enable_tag_value[VALUE_LEN-1:0];

   logic [ID_LEN-1:0]       ids_q [MASTER_NUMS];
   logic [MASTER_NUMS-1:0]  match_w;
   logic [MASTER_NUMS-1:0]  full_w;
   logic [MASTER_NUMS-1:0]  nonempty_w;
   logic                    xfer_w;
   logic [15:0]             drop_q, drop_d;

   // ID scan chain: shifts one position per set_id cycle, id[0] takes the input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MASTER_NUMS; i++) ids_q[i] <= '0;
      end else if (set_id) begin
         ids_q[0] <= id_scan_in;
         for (int i = 1; i < MASTER_NUMS; i++) ids_q[i] <= ids_q[i-1];
      end
   end

   assign id_scan_out = ids_q[MASTER_NUMS-1];

   // Tag match per master; the all-ones tag reaches everyone when broadcast is on
   always_comb begin
      match_w = '0;
      for (int i = 0; i < MASTER_NUMS; i++) begin
         match_w[i] = (tag_w == ids_q[i]) ||
                      ((BCAST_EN != 0) && (tag_w == {ID_LEN{1'b1}}));
      end
   end

   // Ready depends only on IDs, tag and FIFO fullness so the multicast is
   // all-or-nothing; a full FIFO blocks even if it pops this cycle.
   assign ready  = !set_id && (&(~match_w | ~full_w));
   assign xfer_w = enable_w && ready;
   assign busy   = |nonempty_w;

   // Saturating count of accepted transfers that reached no master
   always_comb begin
      drop_d = drop_q;
      if (xfer_w && (match_w == '0) && (drop_q != C_SAT)) drop_d = drop_q + 16'd1;
   end

   // Drop counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_q <= '0;
      else      drop_q <= drop_d;
   end

   assign drop_cnt = drop_q;

   // One FIFO per master; head value comes straight out of the storage array
   for (genvar g = 0; g < MASTER_NUMS; g++) begin : g_master
      logic [VALUE_LEN-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]     wr_q, wr_d;
      logic [PTR_W-1:0]     rd_q, rd_d;
      logic [PTR_W:0]       cnt_q, cnt_d;
      logic                 push_w, pop_w;

      assign push_w        = xfer_w && match_w[g];
      assign pop_w         = nonempty_w[g] && master_ready[g];
      assign full_w[g]     = (cnt_q == C_DEPTH);
      assign nonempty_w[g] = (cnt_q != '0);

      // Pointer and occupancy next state; push+pop together leaves count alone
      always_comb begin
         wr_d  = wr_q;
         rd_d  = rd_q;
         cnt_d = cnt_q;
         if (push_w) wr_d = wr_q + 1'b1;
         if (pop_w)  rd_d = rd_q + 1'b1;
         case ({push_w, pop_w})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      // FIFO state and storage registers
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
         end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_w) mem_q[wr_q] <= value_w;
         end
      end

      assign master_enable_data[g*(VALUE_LEN+1) +: (VALUE_LEN+1)] =
         {nonempty_w[g], mem_q[rd_q]};
   end

endmodule
`default_nettype wire
